// File: rtl/ds1302_time_reader_if.sv
// DS1302 3-wire pin bundle plus the decoded time outputs of ds1302_time_reader.
// Latency: none, wiring only.
// Backpressure: none; time_valid is a one-cycle pulse the consumer must take.
interface ds1302_time_reader_if;
    logic       enable;
    logic       ce;
    logic       sclk;
    logic       dat_out;
    logic       dat_oe;
    logic       dat_in;
    logic [7:0] hr;
    logic [7:0] min;
    logic [7:0] sec;
    logic       time_valid;
    logic       busy;

    modport master (
        input  enable, dat_in,
        output ce, sclk, dat_out, dat_oe, hr, min, sec, time_valid, busy
    );

    modport slave (
        output enable, dat_in,
        input  ce, sclk, dat_out, dat_oe, hr, min, sec, time_valid, busy
    );
endinterface

// File: rtl/ds1302_time_reader.sv
// Polls a DS1302 RTC with a clock burst read and presents hr/min/sec as packed BCD.
// Latency: 68*CLK_DIV cycles from busy rising to the time_valid pulse.
// Backpressure: none; outputs update atomically on the time_valid pulse and hold otherwise.
module ds1302_time_reader #(
    parameter int CLK_DIV     = 100,
    parameter int POLL_CYCLES = 5_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ds1302_time_reader_if.master bus
);
    // Clock burst read command, shifted out LSB first.
    localparam logic [7:0] CMD_BURST_READ = 8'hBF;

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int POLL_W = $clog2(POLL_CYCLES + 1);

    localparam logic [DIV_W-1:0]  DIV_TC  = DIV_W'(CLK_DIV - 1);
    localparam logic [POLL_W-1:0] POLL_TC = POLL_W'(POLL_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        CMD,
        READ,
        HOLD,
        DONE
    } state_t;

    state_t            state;
    logic [DIV_W-1:0]  div_cnt;
    logic [POLL_W-1:0] poll_cnt;
    logic [4:0]        bit_cnt;
    // 0 = first half-period of the current slot (sclk low), 1 = second half.
    logic              phase;
    logic [23:0]       shift;
    logic              div_tc;
    logic              cmd_next;

    assign div_tc   = (div_cnt == DIV_TC);
    assign cmd_next = CMD_BURST_READ[bit_cnt[2:0] + 3'd1];

    // Transaction sequencer: every step outside IDLE/DONE lands on a half-period terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            div_cnt        <= '0;
            poll_cnt       <= POLL_TC;
            bit_cnt        <= '0;
            phase          <= 1'b0;
            shift          <= '0;
            bus.ce         <= 1'b0;
            bus.sclk       <= 1'b0;
            bus.dat_out    <= 1'b0;
            bus.dat_oe     <= 1'b0;
            bus.hr         <= 8'h00;
            bus.min        <= 8'h00;
            bus.sec        <= 8'h00;
            bus.time_valid <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            if (state != IDLE && state != DONE) begin
                div_cnt <= div_tc ? '0 : div_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (bus.enable && (poll_cnt >= POLL_TC)) begin
                        state    <= SETUP;
                        phase    <= 1'b0;
                        div_cnt  <= '0;
                        bus.ce   <= 1'b1;
                        bus.busy <= 1'b1;
                    end else if (poll_cnt < POLL_TC) begin
                        poll_cnt <= poll_cnt + 1'b1;
                    end
                end

                // CE high with SCLK low for two half-periods before the first bit.
                SETUP: begin
                    if (div_tc) begin
                        if (!phase) begin
                            phase <= 1'b1;
                        end else begin
                            phase       <= 1'b0;
                            state       <= CMD;
                            bit_cnt     <= '0;
                            bus.dat_oe  <= 1'b1;
                            bus.dat_out <= CMD_BURST_READ[0];
                        end
                    end
                end

                // Data is set up in the low half and held through the high half.
                CMD: begin
                    if (div_tc) begin
                        if (!phase) begin
                            phase    <= 1'b1;
                            bus.sclk <= 1'b1;
                        end else begin
                            phase    <= 1'b0;
                            bus.sclk <= 1'b0;
                            if (bit_cnt == 5'd7) begin
                                state       <= READ;
                                bit_cnt     <= '0;
                                bus.dat_oe  <= 1'b0;
                                bus.dat_out <= 1'b0;
                            end else begin
                                bit_cnt     <= bit_cnt + 1'b1;
                                bus.dat_out <= cmd_next;
                            end
                        end
                    end
                end

                // Sample on the last clk of each low half; bytes arrive LSB first, so shift right.
                READ: begin
                    if (div_tc) begin
                        if (!phase) begin
                            phase    <= 1'b1;
                            bus.sclk <= 1'b1;
                            shift    <= {bus.dat_in, shift[23:1]};
                        end else begin
                            phase    <= 1'b0;
                            bus.sclk <= 1'b0;
                            if (bit_cnt == 5'd23) begin
                                state   <= HOLD;
                                bit_cnt <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                end

                // Keep CE up one half-period after the last SCLK fall, then drop it for one.
                HOLD: begin
                    if (div_tc) begin
                        if (!phase) begin
                            phase  <= 1'b1;
                            bus.ce <= 1'b0;
                        end else begin
                            phase          <= 1'b0;
                            state          <= DONE;
                            bus.time_valid <= 1'b1;
                            bus.sec        <= shift[7:0]   & 8'h7F;
                            bus.min        <= shift[15:8]  & 8'h7F;
                            bus.hr         <= shift[23:16] & 8'h3F;
                        end
                    end
                end

                DONE: begin
                    bus.time_valid <= 1'b0;
                    bus.busy       <= 1'b0;
                    poll_cnt       <= '0;
                    state          <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ds1302_time_reader.sv
// Self-checking bench for ds1302_time_reader with a DS1302 bus model and a scoreboard.
// Latency: expects time_valid 68*CLK_DIV cycles after busy rises.
// Backpressure: none; the monitor consumes every time_valid pulse.
module tb_ds1302_time_reader;
    localparam int D      = 4;
    localparam int P      = 50;
    localparam int TXN    = 68 * D;
    localparam int PERIOD = TXN + 1 + P + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    ds1302_time_reader_if bus();

    ds1302_time_reader #(.CLK_DIV(D), .POLL_CYCLES(P)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference: {hr, min, sec} from raw {hr, min, sec} register bytes.
    function automatic logic [23:0] ref_time(input logic [23:0] raw);
        int s, m, h;
        s = int'(raw[7:0]) % 128;
        m = int'(raw[15:8]) % 128;
        h = int'(raw[23:16]) % 64;
        return {8'(h), 8'(m), 8'(s)};
    endfunction

    logic [23:0] dir_q[$];
    logic [23:0] exp_q[$];

    // ---------------- DS1302 bus model + framing checks ----------------
    logic [23:0] cur_raw = '0;
    logic [7:0]  cmd_byte = '0;
    int          rise_cnt = 0;
    int          ce_rise_cyc = 0;
    int          ce_rises = 0;
    bit          oe_bad = 1'b0;
    logic        prev_ce = 1'b0, prev_sclk = 1'b0, prev_dout = 1'b0;
    int          dout_bad = 0, edge_bad = 0;

    always @(negedge clk) begin
        if (bus.ce && !prev_ce) begin
            if (dir_q.size() > 0) cur_raw = dir_q.pop_front();
            else cur_raw = 24'($urandom);
            exp_q.push_back(ref_time(cur_raw));
            rise_cnt    = 0;
            cmd_byte    = '0;
            oe_bad      = 1'b0;
            ce_rise_cyc = cyc;
            ce_rises++;
        end
        if (bus.ce && bus.sclk && !prev_sclk) begin
            if (rise_cnt == 0) check("ce_to_first_sclk", cyc - ce_rise_cyc, 3 * D);
            if (rise_cnt < 8) cmd_byte[rise_cnt[2:0]] = bus.dat_out;
            rise_cnt++;
        end
        if (bus.ce && bus.dat_oe && ((rise_cnt >= 8 && !bus.sclk) || rise_cnt >= 9)) oe_bad = 1'b1;
        if (!bus.ce && prev_ce && rst_n) begin
            check("sclk_rises_per_ce", rise_cnt, 32);
            check("cmd_byte", cmd_byte, 8'hBF);
            check("read_oe_low", oe_bad, 0);
        end
        if (bus.dat_out !== prev_dout && bus.sclk) dout_bad++;
        if (bus.ce !== prev_ce && bus.sclk !== prev_sclk) edge_bad++;
        prev_ce   = bus.ce;
        prev_sclk = bus.sclk;
        prev_dout = bus.dat_out;
        bus.dat_in = (rise_cnt >= 8 && rise_cnt < 32) ? cur_raw[rise_cnt - 8] : 1'b0;
    end

    // ---------------- Monitor / scoreboard ----------------
    int          tv_count = 0;
    int          last_busy_rise = -1;
    int          hold_bad = 0;
    int          tv_wide = 0;
    bit          track_period = 1'b0;
    logic        prev_busy = 1'b0, prev_tv = 1'b0;
    logic [23:0] held = '0;

    always @(negedge clk) begin
        logic [23:0] e;
        if (!rst_n) begin
            last_busy_rise = -1;
            exp_q.delete();
        end
        if (bus.busy && !prev_busy) begin
            if (track_period && last_busy_rise >= 0) check("poll_period", cyc - last_busy_rise, PERIOD);
            last_busy_rise = cyc;
        end
        if (bus.time_valid) begin
            tv_count++;
            check("tv_latency", cyc - last_busy_rise, TXN);
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_time_valid: got pulse, expected no pending read");
            end else begin
                e = exp_q.pop_front();
                check("sec", bus.sec, e[7:0]);
                check("min", bus.min, e[15:8]);
                check("hr",  bus.hr,  e[23:16]);
            end
            held = {bus.hr, bus.min, bus.sec};
        end else if (!rst_n) begin
            held = '0;
        end else if ({bus.hr, bus.min, bus.sec} !== held) begin
            hold_bad++;
        end
        if (bus.time_valid && prev_tv) tv_wide++;
        prev_busy = bus.busy;
        prev_tv   = bus.time_valid;
    end

    task automatic wait_tv(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (tv_count < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, tv_count, n);
    endtask

    // ---------------- Stimulus ----------------
    initial begin
        int k;
        int n_ce;
        bus.enable = 1'b0;
        dir_q.push_back(24'h123459);   // basic read
        dir_q.push_back(24'hF2B4D9);   // masking
        dir_q.push_back(24'h125958);   // seconds stepping, then minute/hour rollover
        dir_q.push_back(24'h125959);
        dir_q.push_back(24'h130000);

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_ce", bus.ce, 0);
        check("rst_sclk", bus.sclk, 0);
        check("rst_dat_out", bus.dat_out, 0);
        check("rst_dat_oe", bus.dat_oe, 0);
        check("rst_hr", bus.hr, 0);
        check("rst_min", bus.min, 0);
        check("rst_sec", bus.sec, 0);
        check("rst_time_valid", bus.time_valid, 0);
        check("rst_busy", bus.busy, 0);

        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("disabled_busy", bus.busy, 0);
        check("disabled_ce_rises", ce_rises, 0);

        // Continuous polling: 5 directed + 4 random reads.
        bus.enable   = 1'b1;
        track_period = 1'b1;
        wait_tv(9, 9 * PERIOD + 200, "poll_run_done");

        // Drop enable mid-READ: that read completes, then the bus stays quiet.
        k = 0;
        while (!(bus.ce && rise_cnt == 15) && k < 2 * PERIOD) begin
            @(negedge clk);
            k++;
        end
        check("reach_mid_read", rise_cnt, 15);
        bus.enable   = 1'b0;
        track_period = 1'b0;
        wait_tv(10, PERIOD, "enable_drop_completes");
        n_ce = ce_rises;
        repeat (3 * PERIOD) @(negedge clk);
        check("no_ce_after_disable", ce_rises, n_ce);
        check("idle_after_disable", bus.busy, 0);

        // Reset during command bit 3.
        bus.enable = 1'b1;
        k = 0;
        while (!(bus.ce && rise_cnt == 3 && !bus.sclk) && k < 2 * PERIOD) begin
            @(negedge clk);
            k++;
        end
        check("reach_cmd_bit3", rise_cnt, 3);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ce", bus.ce, 0);
        check("arst_sclk", bus.sclk, 0);
        check("arst_dat_oe", bus.dat_oe, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_time", {bus.hr, bus.min, bus.sec}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("restart_ce", bus.ce, 1);
        check("restart_busy", bus.busy, 1);
        track_period = 1'b1;
        wait_tv(12, 2 * PERIOD + 200, "after_reset_reads");

        check("scoreboard_drained", exp_q.size(), 0);
        check("dat_out_only_sclk_low", dout_bad, 0);
        check("ce_sclk_not_same_cycle", edge_bad, 0);
        check("time_stable_between_pulses", hold_bad, 0);
        check("time_valid_single_cycle", tv_wide, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ds1302_time_reader.md
# ds1302_time_reader

Polls the DS1302 real-time clock over its 3-wire serial interface and presents the current hours, minutes and seconds as packed BCD bytes. It sits directly upstream of the seven-segment display decoder, which consumes `hr`, `min` and `sec`. Each poll is a single burst-read transaction. The outputs are updated atomically only after all three bytes have been received.

## Interface

Parameters:
- `CLK_DIV`, default 100: `clk` cycles per SCLK half-period. At 50 MHz this gives 250 kHz SCLK. Legal range is ≥2.
- `POLL_CYCLES`, default 5_000_000: `clk` cycles from the end of one transaction to the start of the next, i.e. 10 Hz at 50 MHz. Legal range is ≥1.

Ports:
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: asynchronous active-low reset. The clock is the only clock; reset is asynchronous and active-low.
- `enable`, input, 1: allows polling while high.
- `ce`, output, 1: DS1302 CE (RST) pin.
- `sclk`, output, 1: DS1302 SCLK pin.
- `dat_out`, output, 1: value driven onto the DS1302 I/O pin.
- `dat_oe`, output, 1: tri-state enable for the I/O pin. 1 = FPGA drives.
- `dat_in`, input, 1: I/O pin read-back, already synchronised at top level.
- `hr`, output, 8: hours in BCD, `{2'b00, raw[5:0]}`.
- `min`, output, 8: minutes in BCD, `{1'b0, raw[6:0]}`.
- `sec`, output, 8: seconds in BCD, `{1'b0, raw[6:0]}`. The clock-halt bit is stripped.
- `time_valid`, output, 1: one-cycle pulse when `hr`/`min`/`sec` update.
- `busy`, output, 1: high while a transaction is in progress (state ≠ IDLE).

## Operation

- Transaction: clock burst read. The command byte is 0xBF, sent LSB first. This is followed by 24 read bits: seconds, then minutes, then hours, each byte LSB first. CE is then dropped, which terminates the burst early, as the DS1302 permits.
- A half-period counter (0..`CLK_DIV`-1) paces every state except IDLE. All state steps occur on counter terminal count.
- States:
  - IDLE: `ce`=0, `sclk`=0, `dat_oe`=0. The poll counter counts up. Go to SETUP when `enable`=1 and the poll counter ≥ `POLL_CYCLES`. The poll counter resets to `POLL_CYCLES` (expired), so the first transaction starts the cycle after reset release if `enable`=1.
  - SETUP: `ce`=1, `sclk`=0 for 2 half-periods (satisfies tCC). Then go to CMD.
  - CMD, bits 0..7: `dat_oe`=1 and `dat_out`=command bit during the low half. `sclk`=1 during the high half; `dat_out` is held. After the bit-7 high half, go to READ.
  - READ, bits 0..23: `dat_oe`=0 from the first cycle of READ. `sclk`=0 during the low half, and `dat_in` is sampled into a 24-bit shift register on the last `clk` of the low half. `sclk`=1 during the high half. After the bit-23 high half, go to HOLD.
  - HOLD: `sclk`=0, `ce`=1 for 1 half-period, then `ce`=0 for 1 half-period (satisfies tCWH at default settings). Go to DONE.
  - DONE: one cycle. Load `sec`/`min`/`hr` from shift bytes 0/1/2 with the masking above, pulse `time_valid`, clear the poll counter to 0, and go to IDLE.
- `enable` falling mid-transaction: the transaction completes normally, then the block stays in IDLE.
- Masking: `sec[7]`, `min[7]` and `hr[7:6]` are always 0. `hr[5]` is passed through raw; in 12-hour mode it carries the AM/PM flag, and this is by design.
- No BCD validity checking. Raw nibbles pass through; the display shows dashes for invalid digits.

## Timing

- Reset values: `ce`=0, `sclk`=0, `dat_out`=0, `dat_oe`=0, `hr`/`min`/`sec`=0x00, `time_valid`=0, `busy`=0, state IDLE.
- Reset asserted mid-transaction: all outputs return to reset values immediately (asynchronously), so CE drops. The shift register is discarded and outputs keep 0x00.
- Transaction length from SETUP entry to DONE is 68·`CLK_DIV` cycles. `time_valid` asserts exactly 68·`CLK_DIV` cycles after `busy` rises.
- Poll period is 68·`CLK_DIV` + 1 + `POLL_CYCLES` + 1 cycles, start to start.
- `sclk` never changes in the same cycle as `ce` rises or falls.
- `dat_out` changes only while `sclk`=0.
- `hr`/`min`/`sec` change only in the DONE cycle and are stable otherwise.

## Test plan

- **Basic read:** `CLK_DIV`=4, `POLL_CYCLES`=50. The DS1302 bus model returns 0x59, 0x34, 0x12. Required: command bits observed on rising `sclk` edges are 1,1,1,1,1,1,0,1 (0xBF LSB first). Then `sec`=0x59, `min`=0x34, `hr`=0x12, with a single `time_valid` pulse.
- **Masking:** the model returns 0xD9, 0xB4, 0xF2. Required: `sec`=0x59, `min`=0x34, `hr`=0x32.
- **Framing:** count `sclk` rising edges per CE-high window. Required: exactly 32. Also check `ce`↑ to first `sclk`↑ = 3·`CLK_DIV` cycles, and `dat_oe`=0 throughout all READ bits.
- **Polling and enable:** hold `enable` high. Required: successive `busy` rises are 68·4 + 52 = 324 cycles apart. Drop `enable` mid-READ: that transaction still completes with `time_valid`, then no further CE activity.
- **Reset mid-operation:** assert `rst_n`=0 during CMD bit 3. Required: `ce`/`sclk`/`dat_oe` go to 0 before the next `clk` edge and outputs read 0x00. After release with `enable`=1, a new transaction starts on the first clock.
- **Back-to-back data change:** the model increments the seconds value between polls, 0x58 → 0x59 → 0x00 with minutes rolling over. Required: outputs step through each value with no intermediate mixed bytes visible.
